// File: rtl/branch_resolve_controller.sv
// Branch resolution controller: latches a decoded branch, waits for pending flags,
// resolves taken/not-taken from registered NZCV, redirects the PC and holds a flush window.
module branch_resolve_controller #(
  parameter int ADDR_WIDTH   = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  br_valid,
  output logic                  br_ready,
  input  logic [2:0]            br_op,
  input  logic [4:0]            br_cond,
  input  logic                  br_zero,
  input  logic [ADDR_WIDTH-1:0] br_target,
  input  logic                  flags_pending,
  input  logic                  flags_we,
  input  logic [3:0]            flags_in,
  output logic [3:0]            flags_out,
  output logic                  stall,
  output logic                  pc_load,
  output logic [ADDR_WIDTH-1:0] pc_next,
  output logic                  flush,
  output logic [31:0]           taken_cnt,
  output logic [31:0]           not_taken_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_FLAGS, RESOLVE, FLUSH} state_t;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_UNCND = 3'd1;
  localparam logic [2:0] OP_CBZ   = 3'd2;
  localparam logic [2:0] OP_CBNZ  = 3'd3;
  localparam logic [2:0] OP_BCOND = 3'd4;

  state_t                  state_q, state_d;
  logic [2:0]              op_q;
  logic [3:0]              cond_q;
  logic                    zero_q;
  logic [ADDR_WIDTH-1:0]   target_q;
  logic [3:0]              flush_cnt_q;
  logic                    accept;
  logic                    taken;
  logic                    unused_cond4;

  assign unused_cond4 = br_cond[4];

  // ARM-style condition evaluation over {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'd0:    cond_pass = z;
      4'd1:    cond_pass = !z;
      4'd2:    cond_pass = c;
      4'd3:    cond_pass = !c;
      4'd4:    cond_pass = n;
      4'd5:    cond_pass = !n;
      4'd6:    cond_pass = v;
      4'd7:    cond_pass = !v;
      4'd8:    cond_pass = c && !z;
      4'd9:    cond_pass = !c || z;
      4'd10:   cond_pass = (n == v);
      4'd11:   cond_pass = (n != v);
      4'd12:   cond_pass = !z && (n == v);
      4'd13:   cond_pass = z || (n != v);
      4'd14:   cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign accept = (state_q == IDLE) && br_valid && (br_op != OP_NONE);

  // Resolution uses only latched fields and the registered flags
  always_comb begin
    case (op_q)
      OP_UNCND: taken = 1'b1;
      OP_CBZ:   taken = zero_q;
      OP_CBNZ:  taken = !zero_q;
      OP_BCOND: taken = cond_pass(cond_q, flags_out);
      default:  taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    br_ready = 1'b0;
    stall    = 1'b1;
    pc_load  = 1'b0;
    pc_next  = '0;
    flush    = 1'b0;
    case (state_q)
      IDLE: begin
        br_ready = 1'b1;
        stall    = 1'b0;
        if (accept)
          state_d = (br_op == OP_BCOND && flags_pending) ? WAIT_FLAGS : RESOLVE;
      end
      WAIT_FLAGS: begin
        if (!flags_pending)
          state_d = RESOLVE;
      end
      RESOLVE: begin
        pc_load = taken;
        pc_next = taken ? target_q : '0;
        state_d = taken ? FLUSH : IDLE;
      end
      FLUSH: begin
        flush = 1'b1;
        if (flush_cnt_q <= 4'd1)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      op_q          <= '0;
      cond_q        <= '0;
      zero_q        <= 1'b0;
      target_q      <= '0;
      flush_cnt_q   <= '0;
      flags_out     <= '0;
      taken_cnt     <= '0;
      not_taken_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (flags_we)
        flags_out <= flags_in;
      if (accept) begin
        op_q     <= br_op;
        cond_q   <= br_cond[3:0];
        zero_q   <= br_zero;
        target_q <= br_target;
      end
      if (state_q == RESOLVE) begin
        if (taken) begin
          taken_cnt   <= taken_cnt + 32'd1;
          flush_cnt_q <= 4'(FLUSH_CYCLES);
        end else begin
          not_taken_cnt <= not_taken_cnt + 32'd1;
        end
      end else if (state_q == FLUSH) begin
        flush_cnt_q <= flush_cnt_q - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_controller.sv
// Directed bench for branch_resolve_controller: two instances (2- and 4-cycle flush) share stimulus.
module tb_branch_resolve_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_valid;
  logic [2:0]  br_op;
  logic [4:0]  br_cond;
  logic        br_zero;
  logic [63:0] br_target;
  logic        flags_pending;
  logic        flags_we;
  logic [3:0]  flags_in;

  logic        ready_a, stall_a, pc_load_a, flush_a;
  logic [63:0] pc_next_a;
  logic [3:0]  flags_a;
  logic [31:0] tcnt_a, ntcnt_a;
  logic        ready_b, stall_b, pc_load_b, flush_b;
  logic [63:0] pc_next_b;
  logic [3:0]  flags_b;
  logic [31:0] tcnt_b, ntcnt_b;

  int checks = 0;
  int errors = 0;
  int exp_taken;
  int exp_not_taken;

  always #5 clk = ~clk;

  branch_resolve_controller #(.ADDR_WIDTH(64), .FLUSH_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_ready(ready_a), .br_op(br_op),
    .br_cond(br_cond), .br_zero(br_zero), .br_target(br_target), .flags_pending(flags_pending),
    .flags_we(flags_we), .flags_in(flags_in), .flags_out(flags_a), .stall(stall_a),
    .pc_load(pc_load_a), .pc_next(pc_next_a), .flush(flush_a), .taken_cnt(tcnt_a),
    .not_taken_cnt(ntcnt_a)
  );

  branch_resolve_controller #(.ADDR_WIDTH(64), .FLUSH_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_ready(ready_b), .br_op(br_op),
    .br_cond(br_cond), .br_zero(br_zero), .br_target(br_target), .flags_pending(flags_pending),
    .flags_we(flags_we), .flags_in(flags_in), .flags_out(flags_b), .stall(stall_b),
    .pc_load(pc_load_b), .pc_next(pc_next_b), .flush(flush_b), .taken_cnt(tcnt_b),
    .not_taken_cnt(ntcnt_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] cond, input logic zero,
                       input logic [63:0] target);
    br_valid  = 1'b1;
    br_op     = op;
    br_cond   = cond;
    br_zero   = zero;
    br_target = target;
    tick();
    br_valid  = 1'b0;
    br_op     = 3'd0;
  endtask

  function automatic logic ref_cond(input int cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      0: return z;          1: return !z;
      2: return c;          3: return !c;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return c & !z;     9: return !c | z;
      10: return n == v;    11: return n != v;
      12: return !z & (n == v);
      13: return z | (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    reset = 1'b1; br_valid = 1'b0; br_op = '0; br_cond = '0; br_zero = 1'b0;
    br_target = '0; flags_pending = 1'b0; flags_we = 1'b0; flags_in = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_ready", ready_a, 1);
    check("rst_stall", stall_a, 0);
    check("rst_flush", flush_a, 0);
    check("rst_pcload", pc_load_a, 0);
    check("rst_pcnext", pc_next_a, 0);
    check("rst_flags", flags_a, 0);
    check("rst_tcnt", tcnt_a, 0);
    check("rst_ntcnt", ntcnt_a, 0);

    // op 0 with valid is ignored
    issue(3'd0, 5'd0, 1'b0, 64'h10);
    check("op0_ready", ready_a, 1);

    // Unconditional branch to 0x400
    issue(3'd1, 5'd0, 1'b0, 64'h400);
    check("unc_pcload", pc_load_a, 1);
    check("unc_pcnext", pc_next_a, 64'h400);
    check("unc_stall", stall_a, 1);
    check("unc_ready0", ready_a, 0);
    tick();
    check("unc_flush1", flush_a, 1);
    check("unc_pcload_f", pc_load_a, 0);
    check("unc_tcnt", tcnt_a, 1);
    tick();
    check("unc_flush2", flush_a, 1);
    tick();
    check("unc_flush_end", flush_a, 0);
    check("unc_ready", ready_a, 1);
    check("unc_b_flush3", flush_b, 1);
    tick();
    check("unc_b_flush4", flush_b, 1);
    tick();
    check("unc_b_flush_end", flush_b, 0);
    check("unc_b_ready", ready_b, 1);

    // CBNZ with zero=1 is not taken
    issue(3'd3, 5'd0, 1'b1, 64'h123);
    check("cbnz_pcload", pc_load_a, 0);
    check("cbnz_pcnext", pc_next_a, 0);
    tick();
    check("cbnz_ready", ready_a, 1);
    check("cbnz_flush", flush_a, 0);
    check("cbnz_ntcnt", ntcnt_a, 1);

    // Reserved op 6 is never taken; cond bit4 ignored
    issue(3'd6, 5'h1E, 1'b0, 64'h55);
    check("op6_pcload", pc_load_a, 0);
    tick();
    check("op6_ntcnt", ntcnt_a, 2);

    // Flag wait: pending three cycles, flags written on the last
    flags_pending = 1'b1;
    issue(3'd4, 5'd0, 1'b0, 64'h800);
    check("wf_stall1", stall_a, 1);
    check("wf_pcload1", pc_load_a, 0);
    tick();
    check("wf_pcload2", pc_load_a, 0);
    flags_we = 1'b1; flags_in = 4'b0100;
    tick();
    check("wf_pcload3", pc_load_a, 0);
    check("wf_flags", flags_a, 4'b0100);
    flags_we = 1'b0; flags_pending = 1'b0;
    tick();
    check("wf_pcload", pc_load_a, 1);
    check("wf_pcnext", pc_next_a, 64'h800);
    repeat (5) tick();
    check("wf_tcnt", tcnt_a, 2);
    check("wf_ready", ready_b, 1);

    // Condition sweep; a conflicting flag write lands during RESOLVE
    exp_taken = 2; exp_not_taken = 2;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        logic exp_t;
        flags_we = 1'b1; flags_in = 4'(f);
        tick();
        flags_we = 1'b0;
        issue(3'd4, {1'b1, 4'(c)}, 1'b0, 64'hA000 + 64'(c));
        exp_t = ref_cond(c, 4'(f));
        flags_we = 1'b1; flags_in = ~4'(f);
        check($sformatf("cond%0d_f%0h", c, f), pc_load_a, exp_t);
        tick();
        flags_we = 1'b0;
        if (exp_t) begin
          exp_taken++;
          repeat (4) tick();
        end else begin
          exp_not_taken++;
        end
      end
    end
    check("sweep_tcnt", tcnt_a, 32'(exp_taken));
    check("sweep_ntcnt", ntcnt_a, 32'(exp_not_taken));
    check("sweep_tcnt_b", tcnt_b, 32'(exp_taken));

    // Reset during RESOLVE: no redirect, counters cleared
    issue(3'd1, 5'd0, 1'b0, 64'h900);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rres_pcload", pc_load_a, 0);
    check("rres_tcnt", tcnt_a, 0);
    check("rres_ready", ready_a, 1);

    // Reset mid-FLUSH on the 4-cycle instance, overriding a flag write
    flags_we = 1'b1; flags_in = 4'hA;
    tick();
    flags_we = 1'b0;
    issue(3'd1, 5'd0, 1'b0, 64'hB00);
    tick();
    check("mf_flush1", flush_b, 1);
    tick();
    check("mf_flush2", flush_b, 1);
    reset = 1'b1; flags_we = 1'b1; flags_in = 4'hF;
    tick();
    reset = 1'b0; flags_we = 1'b0;
    check("mf_flush", flush_b, 0);
    check("mf_tcnt", tcnt_b, 0);
    check("mf_flags", flags_b, 0);
    check("mf_ready", ready_b, 1);
    check("mf_stall", stall_b, 0);

    // Counter wrap
    force dut_a.taken_cnt = 32'hFFFF_FFFF;
    #1;
    release dut_a.taken_cnt;
    #1;
    check("wrap_pre", tcnt_a, 32'hFFFF_FFFF);
    issue(3'd2, 5'd0, 1'b1, 64'hC00);
    check("wrap_pcload", pc_load_a, 1);
    tick();
    check("wrap_tcnt", tcnt_a, 0);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
